// File: rtl/sram_emu_pkg.sv
// Shared types and helpers for the sram_emu SRAM pin-level emulator.
package sram_emu_pkg;

  localparam int unsigned LANE_W    = 8;
  localparam int unsigned MAX_LANES = 8;  // DATA_W is at most 64

  typedef enum logic [1:0] {
    CMD_IDLE,
    CMD_WR,
    CMD_RD,
    CMD_ERR
  } cmd_t;

  // Expands active-low byte enables into a bit mask; callers narrow it to their DATA_W.
  function automatic logic [MAX_LANES*LANE_W-1:0] lane_mask(input logic [MAX_LANES-1:0] be_n);
    lane_mask = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      lane_mask[i*LANE_W +: LANE_W] = {LANE_W{~be_n[i]}};
    end
  endfunction

endpackage

// File: rtl/sram_emu_rd_pipe.sv
// Read-return pipeline: READ_LAT stages of valid/data, stage 0 loaded at the command edge.
// Data registers only advance behind a valid bit, so the last stage holds the previous read.
module sram_emu_rd_pipe #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic              v_q [READ_LAT];
  logic [DATA_W-1:0] d_q [READ_LAT];

  // Shift valid every cycle; move data only where a valid is moving with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        v_q[i] <= 1'b0;
        d_q[i] <= '0;
      end
    end else begin
      v_q[0] <= in_valid;
      if (in_valid) d_q[0] <= in_data;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        v_q[i] <= v_q[i-1];
        if (v_q[i-1]) d_q[i] <= d_q[i-1];
      end
    end
  end

  assign out_valid = v_q[READ_LAT-1];
  assign out_data  = d_q[READ_LAT-1];

endmodule

// File: rtl/sram_emu.sv
// sram_emu: cycle-based model of an asynchronous SRAM with byte lanes, read latency
// and illegal-command flag. Optional wrapping burst counter under SRAM_BURST_EN.
module sram_emu
  import sram_emu_pkg::*;
#(
  parameter int unsigned ADDR_W    = 22,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned BURST_LEN = 8,
  parameter string       INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce_n,
  input  logic                     ce2,
  input  logic                     we_n,
  input  logic                     oe_n,
  input  logic [DATA_W/LANE_W-1:0] be_n,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        w_data,
  input  logic                     err_clr,
`ifdef SRAM_BURST_EN
  input  logic                     burst_start,
  output logic [ADDR_W-1:0]        burst_addr,
`endif
  output logic [DATA_W-1:0]        r_data,
  output logic                     r_valid,
  output logic                     bus_err
);

  localparam int unsigned NB = DATA_W / LANE_W;

  if (DATA_W % LANE_W != 0 || DATA_W < 8 || DATA_W > 64 || READ_LAT < 1 || READ_LAT > 4 ||
      BURST_LEN < 1 || (BURST_LEN & (BURST_LEN - 1)) != 0) begin : g_bad_params
    $error("sram_emu: unsupported parameter combination");
  end

  logic [DATA_W-1:0]    mem [2**ADDR_W];
  logic [MAX_LANES-1:0] be_ext;
  logic [DATA_W-1:0]    mask;
  logic                 sel;
  cmd_t                 cmd;
  logic [ADDR_W-1:0]    eff_addr;

  // Pin decode: selection, lane mask and command for this edge.
  always_comb begin
    be_ext            = '1;
    be_ext[NB-1:0]    = be_n;
    mask              = DATA_W'(lane_mask(be_ext));
    sel               = !ce_n && ce2 && (|(~be_n));
    cmd               = CMD_IDLE;
    if (sel) begin
      if (!we_n && oe_n)       cmd = CMD_WR;
      else if (we_n && !oe_n)  cmd = CMD_RD;
      else if (!we_n && !oe_n) cmd = CMD_ERR;
    end
  end

`ifdef SRAM_BURST_EN
  localparam logic [ADDR_W-1:0] WRAP_M = ADDR_W'(BURST_LEN - 1);

  logic              burst_on_q;
  cmd_t              burst_cmd_q;
  logic [ADDR_W-1:0] burst_cnt_q;
  logic              burst_go;

  // A burst continues while the same WR/RD command repeats without a fresh burst_start.
  always_comb begin
    burst_go = burst_on_q && (cmd == burst_cmd_q) && (cmd == CMD_WR || cmd == CMD_RD) && !burst_start;
    eff_addr = burst_go ? burst_cnt_q : addr;
  end

  // Burst counter: low bits wrap within BURST_LEN, upper bits stay fixed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_on_q  <= 1'b0;
      burst_cmd_q <= CMD_IDLE;
      burst_cnt_q <= '0;
    end else if ((cmd == CMD_WR || cmd == CMD_RD) && (burst_start || burst_go)) begin
      burst_on_q  <= 1'b1;
      burst_cmd_q <= cmd;
      burst_cnt_q <= (eff_addr & ~WRAP_M) | ((eff_addr + 1'b1) & WRAP_M);
    end else begin
      burst_on_q  <= 1'b0;
    end
  end

  assign burst_addr = eff_addr;
`else
  assign eff_addr = addr;
`endif

  // Byte-masked write; unselected lanes keep their contents.
  always_ff @(posedge clk) begin
    if (cmd == CMD_WR) begin
      mem[eff_addr] <= (mem[eff_addr] & ~mask) | (w_data & mask);
    end
  end

  // Sticky error flag; a new illegal command outranks err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               bus_err <= 1'b0;
    else if (cmd == CMD_ERR)  bus_err <= 1'b1;
    else if (err_clr)         bus_err <= 1'b0;
  end

  sram_emu_rd_pipe #(
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (cmd == CMD_RD),
    .in_data   (mem[eff_addr] & mask),
    .out_valid (r_valid),
    .out_data  (r_data)
  );

endmodule

// File: tb/tb_sram_emu.sv
// Bench for sram_emu: two instances (READ_LAT=1 and 3) share stimulus and are compared
// each cycle against a behavioural memory/queue model. Burst checks under SRAM_BURST_EN.
module tb_sram_emu;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned BL = 8;

  typedef struct {
    int          due;
    logic [15:0] data;
  } rd_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ce_n, ce2, we_n, oe_n, err_clr;
  logic [1:0]    be_n;
  logic [AW-1:0] addr;
  logic [DW-1:0] w_data;
  logic          burst_start;
  logic [DW-1:0] r_data1, r_data3;
  logic          r_valid1, r_valid3, bus_err1, bus_err3;
`ifdef SRAM_BURST_EN
  logic [AW-1:0] burst_addr1, burst_addr3;
`endif

  // model state
  logic [15:0] mem_m [256];
  rd_t         q1[$];
  rd_t         q3[$];
  logic        ev1, ev3, err_m;
  logic [15:0] ed1, ed3;
  int          ecount;
  logic        b_on;
  int          b_cmd, b_beat;
  logic [7:0]  b_base;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sram_emu #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .BURST_LEN(BL)) u_lat1 (
`ifdef SRAM_BURST_EN
    .burst_start (burst_start),
    .burst_addr  (burst_addr1),
`endif
    .clk (clk), .rst_n (rst_n), .ce_n (ce_n), .ce2 (ce2), .we_n (we_n), .oe_n (oe_n),
    .be_n (be_n), .addr (addr), .w_data (w_data), .err_clr (err_clr),
    .r_data (r_data1), .r_valid (r_valid1), .bus_err (bus_err1)
  );

  sram_emu #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(3), .BURST_LEN(BL)) u_lat3 (
`ifdef SRAM_BURST_EN
    .burst_start (burst_start),
    .burst_addr  (burst_addr3),
`endif
    .clk (clk), .rst_n (rst_n), .ce_n (ce_n), .ce2 (ce2), .we_n (we_n), .oe_n (oe_n),
    .be_n (be_n), .addr (addr), .w_data (w_data), .err_clr (err_clr),
    .r_data (r_data3), .r_valid (r_valid3), .bus_err (bus_err3)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  // One clock: update the model from the pins, take the edge, compare registered outputs.
  task automatic cycle();
    int          cmd;
    logic        sel;
    logic [7:0]  a;
    logic [15:0] rdv;
    #1;
    sel = !ce_n && ce2 && (be_n != 2'b11);
    cmd = !sel ? 0 : (!we_n && oe_n) ? 1 : (we_n && !oe_n) ? 2 : (!we_n && !oe_n) ? 3 : 0;
    a   = addr;
`ifdef SRAM_BURST_EN
    if ((cmd == 1 || cmd == 2) && burst_start) begin
      b_on = 1'b1; b_cmd = cmd; b_base = addr; b_beat = 0;
    end else if (b_on && cmd == b_cmd) begin
      b_beat++;
      a = (b_base & ~8'(BL - 1)) | (8'(int'(b_base) + b_beat) & 8'(BL - 1));
    end else begin
      b_on = 1'b0;
    end
    if (cmd == 1 || cmd == 2) begin
      check_val("burst_addr1", 64'(burst_addr1), 64'(a));
      check_val("burst_addr3", 64'(burst_addr3), 64'(a));
    end
`endif
    if (cmd == 1) begin
      if (!be_n[0]) mem_m[a][7:0]  = w_data[7:0];
      if (!be_n[1]) mem_m[a][15:8] = w_data[15:8];
    end else if (cmd == 2) begin
      rdv = mem_m[a];
      if (be_n[0]) rdv[7:0]  = 8'h00;
      if (be_n[1]) rdv[15:8] = 8'h00;
      q1.push_back('{due: ecount,     data: rdv});
      q3.push_back('{due: ecount + 2, data: rdv});
    end
    if (cmd == 3)     err_m = 1'b1;
    else if (err_clr) err_m = 1'b0;

    @(posedge clk);
    #1;
    ev1 = 1'b0;
    if (q1.size() > 0 && q1[0].due == ecount) begin ev1 = 1'b1; ed1 = q1[0].data; void'(q1.pop_front()); end
    ev3 = 1'b0;
    if (q3.size() > 0 && q3[0].due == ecount) begin ev3 = 1'b1; ed3 = q3[0].data; void'(q3.pop_front()); end
    ecount++;
    check_val("r_valid1", 64'(r_valid1), 64'(ev1));
    check_val("r_data1",  64'(r_data1),  64'(ed1));
    check_val("r_valid3", 64'(r_valid3), 64'(ev3));
    check_val("r_data3",  64'(r_data3),  64'(ed3));
    check_val("bus_err1", 64'(bus_err1), 64'(err_m));
    check_val("bus_err3", 64'(bus_err3), 64'(err_m));
  endtask

  task automatic pins(input logic cen, input logic c2, input logic wen, input logic oen,
                      input logic [1:0] be, input logic [7:0] a, input logic [15:0] d);
    ce_n = cen; ce2 = c2; we_n = wen; oe_n = oen; be_n = be; addr = a; w_data = d;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
    pins(1'b0, 1'b1, 1'b0, 1'b1, be, a, d); cycle();
  endtask

  task automatic rd(input logic [7:0] a, input logic [1:0] be);
    pins(1'b0, 1'b1, 1'b1, 1'b0, be, a, 16'h0); cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      pins(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 8'h00, 16'h0); cycle();
    end
  endtask

  // Asynchronous reset pulse between edges; outputs must clear immediately.
  task automatic pulse_reset();
    pins(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 8'h00, 16'h0);
    err_clr = 1'b0; burst_start = 1'b0;
    rst_n = 1'b0;
    #1;
    q1.delete(); q3.delete();
    ev1 = 1'b0; ev3 = 1'b0; ed1 = '0; ed3 = '0; err_m = 1'b0; b_on = 1'b0;
    check_val("rst_r_valid1", 64'(r_valid1), 64'(0));
    check_val("rst_r_valid3", 64'(r_valid3), 64'(0));
    check_val("rst_r_data3",  64'(r_data3),  64'(0));
    check_val("rst_bus_err",  64'(bus_err1 | bus_err3), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    ecount = 0; b_on = 1'b0; b_cmd = 0; b_beat = 0; b_base = '0;
    ev1 = 1'b0; ev3 = 1'b0; ed1 = '0; ed3 = '0; err_m = 1'b0;
    err_clr = 1'b0; burst_start = 1'b0; rst_n = 1'b1;
    pins(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 8'h00, 16'h0);
    @(posedge clk); #1;
    pulse_reset();

    // preload every word so all later reads have a defined reference
    for (int i = 0; i < 256; i++) wr(8'(i), 16'($urandom), 2'b00);

    // basic write/read, latency 1
    wr(8'h10, 16'hBEEF, 2'b00);
    rd(8'h10, 2'b00);
    check_val("t1_data", 64'(r_data1), 64'h BEEF);
    check_val("t1_valid", 64'(r_valid1), 64'(1));
    idle(1);
    check_val("t1_valid_drop", 64'(r_valid1), 64'(0));

    // byte lanes
    wr(8'h10, 16'h1234, 2'b10);
    rd(8'h10, 2'b00);
    check_val("t2_lo_lane", 64'(r_data1), 64'h BE34);
    rd(8'h10, 2'b01);
    check_val("t2_masked", 64'(r_data1), 64'h BE00);

    // deselected and no-lane writes are ignored
    wr(8'h20, 16'h5555, 2'b00);
    pins(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 8'h20, 16'hAAAA); cycle();
    pins(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 8'h20, 16'hAAAA); cycle();
    wr(8'h20, 16'hAAAA, 2'b11);
    rd(8'h20, 2'b00);
    check_val("t3_deselect", 64'(r_data1), 64'h5555);

    // illegal command
    pins(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 8'h20, 16'h0000); cycle();
    check_val("t4_err_set", 64'(bus_err1), 64'(1));
    check_val("t4_no_valid", 64'(r_valid1), 64'(0));
    idle(10);
    check_val("t4_err_hold", 64'(bus_err1), 64'(1));
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    check_val("t4_err_clr", 64'(bus_err1), 64'(0));
    pins(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 8'h20, 16'h0000); cycle();
    err_clr = 1'b1;
    pins(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 8'h20, 16'h0000); cycle();
    check_val("t4_set_wins", 64'(bus_err1), 64'(1));
    idle(1); err_clr = 1'b0;
    rd(8'h20, 2'b00);
    check_val("t4_mem_kept", 64'(r_data1), 64'h5555);

    // latency 3, back-to-back reads
    wr(8'h00, 16'h0011, 2'b00);
    wr(8'h01, 16'h0022, 2'b00);
    wr(8'h02, 16'h0033, 2'b00);
    rd(8'h00, 2'b00);
    check_val("t5_v_e0", 64'(r_valid3), 64'(0));
    rd(8'h01, 2'b00);
    check_val("t5_v_e1", 64'(r_valid3), 64'(0));
    rd(8'h02, 2'b00);
    check_val("t5_d0", 64'({r_valid3, r_data3}), 64'h1_0011);
    idle(1);
    check_val("t5_d1", 64'({r_valid3, r_data3}), 64'h1_0022);
    idle(1);
    check_val("t5_d2", 64'({r_valid3, r_data3}), 64'h1_0033);
    idle(1);
    check_val("t5_v_end", 64'(r_valid3), 64'(0));

    // reset kills an in-flight read but keeps memory
    rd(8'h00, 2'b00);
    pulse_reset();
    idle(4);
    rd(8'h00, 2'b00);
    idle(2);
    check_val("t5_after_rst", 64'({r_valid3, r_data3}), 64'h1_0011);

`ifdef SRAM_BURST_EN
    // wrapping burst write then burst read
    burst_start = 1'b1; wr(8'h06, 16'h00A0, 2'b00); burst_start = 1'b0;
    wr(8'h55, 16'h00A1, 2'b00);
    wr(8'h55, 16'h00A2, 2'b00);
    wr(8'h55, 16'h00A3, 2'b00);
    idle(1);
    rd(8'h06, 2'b00); check_val("t6_w6", 64'(r_data1), 64'h00A0);
    rd(8'h07, 2'b00); check_val("t6_w7", 64'(r_data1), 64'h00A1);
    rd(8'h00, 2'b00); check_val("t6_w0", 64'(r_data1), 64'h00A2);
    rd(8'h01, 2'b00); check_val("t6_w1", 64'(r_data1), 64'h00A3);
    idle(1);
    burst_start = 1'b1; rd(8'h06, 2'b00); burst_start = 1'b0;
    check_val("t6_r0", 64'(r_data1), 64'h00A0);
    rd(8'h33, 2'b00); check_val("t6_r1", 64'(r_data1), 64'h00A1);
    rd(8'h33, 2'b00); check_val("t6_r2", 64'(r_data1), 64'h00A2);
    rd(8'h33, 2'b00); check_val("t6_r3", 64'(r_data1), 64'h00A3);
    idle(1);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 9);
      pins(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) != 0),
           (r < 4 || r == 8) ? 1'b0 : 1'b1,
           (r >= 4 && r <= 8) ? 1'b0 : 1'b1,
           2'($urandom), 8'($urandom_range(0, 31)), 16'($urandom));
      err_clr     = ($urandom_range(0, 3) == 0);
      burst_start = ($urandom_range(0, 4) == 0);
      cycle();
    end
    err_clr = 1'b0; burst_start = 1'b0;
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
